// File: rtl/run_event_logger_pkg.sv
// rtl/run_event_logger_pkg.sv - shared defaults for the run event logger slice
package run_event_logger_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/run_event_logger_fifo.sv
// rtl/run_event_logger_fifo.sv - first-word-fall-through FIFO of completed run lengths
module run_len_fifo
  import run_event_logger_pkg::*;
#(
  parameter int W     = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/run_event_logger.sv
// rtl/run_event_logger.sv - measures runs flagged by z and queues their lengths
module run_event_logger
  import run_event_logger_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LEN_W-1:0] out_data,
  output logic [CNT_W-1:0] evt_count,
  output logic             busy,
  output logic             overflow
);

  logic             z_q, z_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             run_start;
  logic             run_end;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign run_start = z & ~z_q;
  assign run_end   = ~z & z_q;
  assign fifo_push = run_end & ~clr;
  assign fifo_pop  = out_valid & out_ready;

  assign out_valid = ~fifo_empty;
  assign evt_count = cnt_q;
  assign busy      = z_q;
  assign overflow  = ovf_q;

  always_comb begin
    z_d   = z;
    len_d = len_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      z_d   = 1'b0;
      len_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (run_start) begin
        len_d = LEN_W'(1);
      end else if (z && z_q && len_q != {LEN_W{1'b1}}) begin
        len_d = len_q + LEN_W'(1);
      end
      if (run_end && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // The run is still counted even when its length cannot be queued.
      if (fifo_push && fifo_full && !fifo_pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q   <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  run_len_fifo #(
    .W     (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (fifo_push),
    .wdata (len_q),
    .pop   (fifo_pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
